// File: rtl/lcd_frame_prefetch.sv
// Frame prefetcher: reads one frame from SDRAM in bursts into a FIFO and serves LCD pixel requests.
// Optional build macro LCD_UNDERFLOW_CNT_EN enables the saturating underflow event counter.
module lcd_frame_prefetch #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 24,
  parameter int H_DISP     = 800,
  parameter int V_DISP     = 480,
  parameter int FRAME_BASE = 0,
  parameter int BURST_LEN  = 128,
  parameter int FIFO_DEPTH = 512,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lcd_request,
  input  logic              lcd_framesync,
  output logic [DATA_W-1:0] lcd_data,
  output logic              rd_burst_req,
  output logic [ADDR_W-1:0] rd_burst_addr,
  output logic [9:0]        rd_burst_len,
  input  logic              rd_burst_ack,
  input  logic              rd_data_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int FRAME_WORDS = H_DISP * V_DISP;
  localparam int RW_W        = $clog2(FRAME_WORDS + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;
  state_t state;

  logic [RW_W-1:0]   req_words;
  logic [9:0]        word_cnt;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic        fifo_empty, fifo_full, space_ok, more_words;
  logic [31:0] remaining;
  logic [9:0]  next_len;
  logic        burst_last, restart, wr_en, wr_ok, pop, drop;

  always_comb begin
    fifo_cnt   = wr_ptr - rd_ptr;
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (32'(fifo_cnt) == 32'(FIFO_DEPTH));
    space_ok   = (32'(FIFO_DEPTH) - 32'(fifo_cnt)) >= 32'(BURST_LEN);
    more_words = 32'(req_words) < 32'(FRAME_WORDS);
    remaining  = 32'(FRAME_WORDS) - 32'(req_words);
    next_len   = (remaining < 32'(BURST_LEN)) ? remaining[9:0] : 10'(BURST_LEN);
    burst_last = rd_data_valid && ((word_cnt + 10'd1) == rd_burst_len);
    // Flush happens only once no more burst words are owed by the controller.
    restart    = (state == IDLE  && lcd_framesync) ||
                 (state == REQ   && lcd_framesync && !rd_burst_ack) ||
                 (state == DATA  && lcd_framesync && burst_last) ||
                 (state == DRAIN && burst_last);
    wr_en      = (state == DATA) && rd_data_valid && !lcd_framesync;
    pop        = lcd_request && !lcd_framesync && !fifo_empty;
    wr_ok      = wr_en && (!fifo_full || pop);
    drop       = wr_en && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_words     <= '0;
      word_cnt      <= '0;
      rd_burst_req  <= 1'b0;
      rd_burst_addr <= ADDR_W'(FRAME_BASE);
      rd_burst_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lcd_framesync) begin
            req_words <= '0;
          end else if (more_words && space_ok) begin
            state         <= REQ;
            rd_burst_req  <= 1'b1;
            rd_burst_addr <= ADDR_W'(FRAME_BASE) + ADDR_W'(req_words);
            rd_burst_len  <= next_len;
          end
        end
        REQ: begin
          if (rd_burst_ack) begin
            rd_burst_req <= 1'b0;
            req_words    <= req_words + RW_W'(rd_burst_len);
            word_cnt     <= '0;
            state        <= lcd_framesync ? DRAIN : DATA;
          end else if (lcd_framesync) begin
            rd_burst_req <= 1'b0;
            req_words    <= '0;
            state        <= IDLE;
          end
        end
        DATA: begin
          if (rd_data_valid) word_cnt <= word_cnt + 10'd1;
          if (burst_last) begin
            state <= IDLE;
            if (lcd_framesync) req_words <= '0;
          end else if (lcd_framesync) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_data_valid) word_cnt <= word_cnt + 10'd1;
          if (burst_last) begin
            state     <= IDLE;
            req_words <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[PTR_W-1:0]] <= rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lcd_data  <= UNDERFLOW_COLOR;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (restart)  rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Framesync overrides any pixel request in the same cycle.
      if (lcd_framesync) begin
        lcd_data <= UNDERFLOW_COLOR;
      end else if (lcd_request) begin
        if (!fifo_empty) begin
          lcd_data <= mem[rd_ptr[PTR_W-1:0]];
        end else begin
          lcd_data  <= UNDERFLOW_COLOR;
          underflow <= 1'b1;
        end
      end
      if (drop) underflow <= 1'b1;
    end
  end

`ifdef LCD_UNDERFLOW_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_cnt <= '0;
    end else if (lcd_request && !lcd_framesync && fifo_empty && underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_lcd_frame_prefetch.sv
// Directed bench for lcd_frame_prefetch with a small frame (40x20) and a burst-reading SDRAM model.
module tb_lcd_frame_prefetch;
  localparam int H  = 40;
  localparam int V  = 20;
  localparam int FW = H * V;
  localparam int BL = 128;
  localparam logic [15:0] UF = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lcd_request = 1'b0;
  logic        lcd_framesync = 1'b0;
  logic [15:0] lcd_data;
  logic        rd_burst_req;
  logic [23:0] rd_burst_addr;
  logic [9:0]  rd_burst_len;
  logic        rd_burst_ack;
  logic        rd_data_valid;
  logic [15:0] rd_data;
  logic        underflow;
  logic [15:0] underflow_cnt;

  lcd_frame_prefetch #(
    .DATA_W(16), .ADDR_W(24), .H_DISP(H), .V_DISP(V), .FRAME_BASE(0),
    .BURST_LEN(BL), .FIFO_DEPTH(512), .UNDERFLOW_COLOR(UF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lcd_request(lcd_request), .lcd_framesync(lcd_framesync),
    .lcd_data(lcd_data), .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr),
    .rd_burst_len(rd_burst_len), .rd_burst_ack(rd_burst_ack), .rd_data_valid(rd_data_valid),
    .rd_data(rd_data), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  // clock/reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] w(input int i);
    return 16'(i) + 16'h1000;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // SDRAM controller model: ack two cycles after a request, then data back-to-back.
  logic ctrl_en = 1'b0;
  logic ctrl_busy = 1'b0;
  int   burst_word = 0;
  int   ctrl_a, ctrl_l;
  int   log_addr[$], log_len[$], rise_cyc[$], end_cyc[$];
  logic mon_prev = 1'b0;

  initial begin
    rd_burst_ack = 1'b0; rd_data_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (ctrl_en && rst_n && rd_burst_req) begin
        ctrl_busy = 1'b1;
        repeat (2) @(negedge clk);
        if (rd_burst_req && rst_n) begin
          ctrl_a = int'(rd_burst_addr); ctrl_l = int'(rd_burst_len);
          log_addr.push_back(ctrl_a); log_len.push_back(ctrl_l);
          rd_burst_ack = 1'b1; burst_word = 0;
          @(negedge clk);
          rd_burst_ack = 1'b0;
          for (int i = 0; i < ctrl_l; i++) begin
            rd_data_valid = 1'b1; rd_data = w(ctrl_a + i);
            @(negedge clk);
            burst_word = i + 1;
          end
          rd_data_valid = 1'b0;
          end_cyc.push_back(cyc);
        end
        ctrl_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rd_burst_req && !mon_prev) rise_cyc.push_back(cyc);
      mon_prev = rd_burst_req;
    end
  end

  // driver tasks
  task automatic clear_logs();
    log_addr.delete(); log_len.delete(); rise_cyc.delete(); end_cyc.delete();
  endtask

  task automatic wait_ctrl_idle(input string name);
    int k = 0;
    while ((ctrl_busy || rd_burst_req) && k < 3000) begin @(negedge clk); k++; end
    chk(name, 32'(ctrl_busy || rd_burst_req), 0);
  endtask

  task automatic do_reset(input logic en);
    int k = 0;
    while (ctrl_busy && k < 3000) begin @(negedge clk); k++; end
    @(negedge clk);
    lcd_request = 1'b0; lcd_framesync = 1'b0; rst_n = 1'b0; ctrl_en = en;
    clear_logs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_addr.size() < n && k < budget) begin @(negedge clk); k++; end
    chk(name, 32'(log_addr.size() >= n), 1);
  endtask

  task automatic pix(input logic req, input logic fs);
    lcd_request = req; lcd_framesync = fs;
    @(negedge clk);
    lcd_request = 1'b0; lcd_framesync = 1'b0;
  endtask

  typedef struct {
    logic        req;
    logic        fs;
    logic [15:0] data;
    logic        uf;
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [15:0] last;
    int k;
    int sum;
    tbl[0] = '{1'b1, 1'b0, w(0), 1'b0};
    tbl[1] = '{1'b0, 1'b0, w(0), 1'b0};
    tbl[2] = '{1'b1, 1'b0, w(1), 1'b0};
    tbl[3] = '{1'b1, 1'b0, w(2), 1'b0};
    tbl[4] = '{1'b0, 1'b0, w(2), 1'b0};
    tbl[5] = '{1'b1, 1'b1, UF,   1'b0};
    tbl[6] = '{1'b0, 1'b0, UF,   1'b0};

    // reset values
    ctrl_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_lcd_data", 32'(lcd_data), 32'(UF));
    chk("rst_req", 32'(rd_burst_req), 0);
    chk("rst_addr", 32'(rd_burst_addr), 0);
    chk("rst_len", 32'(rd_burst_len), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_underflow_cnt", 32'(underflow_cnt), 0);
    clear_logs();
    rst_n = 1'b1;

    // fill: four bursts of 128, then the FIFO is full
    wait_log(4, 2000, "fill_four_bursts");
    wait_ctrl_idle("fill_idle");
    repeat (60) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill_addr%0d", i), 32'(qget(log_addr, i)), 32'(i * BL));
      chk($sformatf("fill_len%0d", i), 32'(qget(log_len, i)), 32'(BL));
    end
    chk("second_req_after_first_burst", 32'(qget(rise_cyc, 1) > qget(end_cyc, 0)), 1);
    chk("no_fifth_req", 32'(log_addr.size()), 4);
    chk("req_low_when_full", 32'(rd_burst_req), 0);

    // table: pops, hold, framesync+request together
    clear_logs();
    for (int i = 0; i < 7; i++) begin
      pix(tbl[i].req, tbl[i].fs);
      chk($sformatf("vec%0d_data", i), 32'(lcd_data), 32'(tbl[i].data));
      chk($sformatf("vec%0d_uf", i), 32'(underflow), 32'(tbl[i].uf));
    end

    // full frame after framesync restart
    wait_log(4, 2000, "refill_four_bursts");
    wait_ctrl_idle("refill_idle");
    chk("restart_addr", 32'(qget(log_addr, 0)), 0);
    chk("restart_len", 32'(qget(log_len, 0)), 32'(BL));
    for (int i = 0; i < FW; i++) exp_q.push_back(w(i));
    last = UF;
    for (int ln = 0; ln < V; ln++) begin
      for (int px = 0; px < H; px++) begin
        lcd_request = 1'b1;
        @(negedge clk);
        last = exp_q.pop_front();
        chk("frame_pixel", 32'(lcd_data), 32'(last));
      end
      lcd_request = 1'b0;
      repeat (4) @(negedge clk);
      chk("blank_hold", 32'(lcd_data), 32'(last));
    end
    repeat (400) @(negedge clk);
    chk("frame_underflow", 32'(underflow), 0);
    chk("frame_req_count", 32'(log_addr.size()), 7);
    chk("frame_last_addr", 32'(qget(log_addr, 6)), 768);
    chk("frame_last_len", 32'(qget(log_len, 6)), 32);
    sum = 0;
    foreach (log_len[i]) sum += log_len[i];
    chk("frame_words_requested", 32'(sum), 32'(FW));
    chk("frame_no_more_req", 32'(rd_burst_req), 0);

    // framesync mid-burst after 40 words
    do_reset(1'b1);
    k = 0;
    while (!(log_addr.size() >= 1 && burst_word >= 40) && k < 400) begin
      @(posedge clk); #1; k++;
    end
    chk("mid_reached_40", 32'(burst_word >= 40), 1);
    @(negedge clk);
    pix(1'b0, 1'b1);
    chk("mid_fs_data", 32'(lcd_data), 32'(UF));
    wait_log(2, 400, "mid_next_req");
    chk("mid_next_addr", 32'(qget(log_addr, 1)), 0);
    chk("mid_next_len", 32'(qget(log_len, 1)), 32'(BL));
    repeat (150) @(negedge clk);
    pix(1'b1, 1'b0);
    chk("mid_first_pixel", 32'(lcd_data), 32'(w(0)));
    pix(1'b1, 1'b0);
    chk("mid_second_pixel", 32'(lcd_data), 32'(w(1)));
    chk("mid_underflow", 32'(underflow), 0);

    // underflow with a controller that never acks
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      pix(1'b1, 1'b0);
      chk("uf_data", 32'(lcd_data), 32'(UF));
      chk("uf_flag", 32'(underflow), 1);
    end
    @(negedge clk);
`ifdef LCD_UNDERFLOW_CNT_EN
    chk("uf_count", 32'(underflow_cnt), 10);
`else
    chk("uf_count", 32'(underflow_cnt), 0);
`endif
    chk("uf_req_held", 32'(rd_burst_req), 1);
    chk("uf_req_addr", 32'(rd_burst_addr), 0);
    chk("uf_req_len", 32'(rd_burst_len), 32'(BL));

    // asynchronous reset while a request is pending
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(rd_burst_req), 0);
    chk("async_rst_underflow", 32'(underflow), 0);
    chk("async_rst_cnt", 32'(underflow_cnt), 0);
    @(negedge clk);
    ctrl_en = 1'b1;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_log(1, 50, "post_rst_req");
    chk("post_rst_addr", 32'(qget(log_addr, 0)), 0);
    chk("post_rst_len", 32'(qget(log_len, 0)), 32'(BL));

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcd_frame_prefetch.md
Name: lcd_frame_prefetch

Overview:
- Upstream neighbour of the LCD display driver: fetches one 800x480 RGB565 frame per display frame from the SDRAM read port through burst requests.
- Buffers pixels in an internal FIFO and answers the driver's lcd_request / lcd_framesync with lcd_data.
- Single clock domain: the SDRAM user read port and the LCD pixel logic share clk.

Parameters:
- DATA_W, 16: pixel and SDRAM word width.
- ADDR_W, 24: SDRAM word-address width.
- H_DISP, 800: active pixels per line.
- V_DISP, 480: active lines per frame.
- FRAME_BASE, 0: SDRAM word address of pixel (0,0).
- BURST_LEN, 128: maximum words per read burst.
- FIFO_DEPTH, 512: FIFO words; must be a power of two and >= 2*BURST_LEN.
- UNDERFLOW_COLOR, 16'h0000: pixel driven when no data is available.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- lcd_request  in  1  driver pixel request; one pixel consumed per high cycle
- lcd_framesync  in  1  one-cycle pulse at frame start, during vertical blank
- lcd_data  out  DATA_W  pixel to driver; registered
- rd_burst_req  out  1  burst request to SDRAM controller
- rd_burst_addr  out  ADDR_W  burst start word address
- rd_burst_len  out  10  burst length in words
- rd_burst_ack  in  1  one-cycle accept of the current request
- rd_data_valid  in  1  read word valid
- rd_data  in  DATA_W  read word
- underflow  out  1  sticky: a request was made while the FIFO was empty
- underflow_cnt  out  16  underflow event counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n low):
  - lcd_data = UNDERFLOW_COLOR; rd_burst_req = 0; rd_burst_addr = FRAME_BASE; rd_burst_len = 0.
  - underflow = 0; underflow_cnt = 0; FIFO empty; word counters 0; state IDLE.
- Frame size: FRAME_WORDS = H_DISP*V_DISP (384000). req_words counts words requested in the current frame.
- FSM states: IDLE, REQ, DATA, DRAIN.
  - IDLE -> REQ when req_words < FRAME_WORDS and FIFO free space >= BURST_LEN.
    - On entry: rd_burst_addr = FRAME_BASE + req_words.
    - On entry: rd_burst_len = min(BURST_LEN, FRAME_WORDS - req_words).
  - REQ: hold rd_burst_req = 1 with addr and len stable until rd_burst_ack. On ack: req_words += len, drop req the same edge, go to DATA.
  - DATA: write each rd_data_valid word into the FIFO; count the words. When the count reaches len, go to IDLE.
  - DRAIN: entered on lcd_framesync while in REQ (after ack) or DATA. Discard rd_data_valid words until the burst count completes, then do the frame restart and go to IDLE.
- Frame restart, on lcd_framesync in IDLE, or when DRAIN completes:
  - Flush the FIFO; req_words = 0.
  - Clear nothing else; underflow stays sticky.
  - A framesync in REQ before ack drops the request at once, then restarts.
- Pixel output: lcd_data is registered, valid the cycle after lcd_request is high. Latency 1.
  - Request with FIFO non-empty: pop one word; next lcd_data = that word.
  - Request with FIFO empty: lcd_data = UNDERFLOW_COLOR; set underflow.
  - No request: lcd_data holds.
- Simultaneous events:
  - FIFO write and read in the same cycle are both performed; the count is unchanged.
  - lcd_framesync and lcd_request in the same cycle: framesync wins. The request is ignored, lcd_data = UNDERFLOW_COLOR, no underflow is flagged.
  - rd_data_valid while the FIFO is full cannot occur, because space is checked before each request. If it does occur, drop the word and set underflow.
- Wrap: after FRAME_WORDS words are requested, no more requests until the next framesync. Addresses never exceed FRAME_BASE + FRAME_WORDS - 1.
- Reset mid-burst: everything returns to reset values immediately. The SDRAM controller is reset by the same rst_n.

Optional Feature:
- Macro: LCD_UNDERFLOW_CNT_EN.
- Defined: underflow_cnt increments by 1 for each lcd_request cycle served with UNDERFLOW_COLOR (framesync cycles excluded). It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: underflow_cnt is tied to 0 and no counter logic is generated. The underflow flag behaves identically in both builds.

Test Plan:
- Reset, then an ideal controller (ack after 2 cycles, data back-to-back) -> first request addr=0 len=128. Second request addr=128 only after the first burst completes. FIFO fills to 512; no fifth request.
- framesync, then 800 lcd_request cycles per line for 480 lines -> lcd_data sequence equals SDRAM word index 0..383999. underflow = 0. Last request addr=383872 len=128, then no further requests.
- lcd_request held while FIFO empty (controller never acks) -> lcd_data = 16'h0000 the next cycle, underflow = 1. With LCD_UNDERFLOW_CNT_EN, underflow_cnt = number of request cycles (e.g. 10 after 10).
- lcd_framesync mid-burst after 40 of 128 words -> remaining 88 words discarded. FIFO flushed; next request addr=0 len=128. First pixel of the new frame = word 0.
- lcd_framesync and lcd_request in the same cycle with FIFO non-empty -> no pop; lcd_data = UNDERFLOW_COLOR; underflow unchanged.
- rst_n pulled low during REQ -> rd_burst_req = 0 asynchronously. After release, first request addr=0.
